// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared encodings and step functions for the ALU self-test controller
package alu_bist_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction
    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [7:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? MISR_POLY : 16'h0000) ^ {8'h00, d};
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: operand generator; its register doubles as the a/b output flops, so it is zero outside a run
module lfsr16
    import alu_bist_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] q_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) q_o <= 16'h0000;
        else if (load_i) q_o <= SEED;
        else if (adv_i) q_o <= lfsr_step(q_o);
    end
endmodule

// File: rtl/alu_8_bit_bist.sv
// alu_8_bit_bist: sweeps LFSR operand pairs through all opcodes and compacts alu_i into a MISR signature
module alu_8_bit_bist
    import alu_bist_pkg::*;
#(
    parameter int          NUM_VECTORS = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG  = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic [7:0]  a_o,
    output logic [7:0]  b_o,
    output logic [2:0]  op_o,
    input  logic [7:0]  alu_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] signature_o
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? ZERO_SEED_SUB : LFSR_SEED;
    localparam logic [11:0] LAST_VEC = 12'(NUM_VECTORS - 1);
    state_t state, state_nxt;
    logic [11:0] vec;
    logic [15:0] misr;
    logic go, wrap, last;
    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (last),
        .load_i (go),
        .adv_i  (wrap),
        .q_o    ({a_o, b_o})
    );
    assign signature_o = misr;
    always_comb begin
        go = start_i && (state == IDLE || state == DONE);
        wrap = state == RUN && op_o == 3'd7;
        last = wrap && vec == LAST_VEC;
        state_nxt = go ? RUN : last ? CHECK : state == CHECK ? DONE : state;
        busy_o = state == RUN || state == CHECK;
        done_o = state == DONE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            vec <= 12'd0;
            misr <= 16'h0000;
            op_o <= 3'd0;
            pass_o <= 1'b0;
        end else begin
            state <= state_nxt;
            vec <= go ? 12'd0 : wrap ? vec + 12'd1 : vec;
            misr <= go ? 16'h0000 : state == RUN ? misr_step(misr, alu_i) : misr;
            op_o <= (state == RUN && !last) ? op_o + 3'd1 : 3'd0;
            pass_o <= go ? 1'b0 : state == CHECK ? misr == GOLDEN_SIG : pass_o;
        end
    end
endmodule

// File: tb/tb_alu_8_bit_bist.sv
// tb_alu_8_bit_bist: four controllers (stub ALU, bench ALU with matching/mismatching golden, random results)
// checked every cycle against a run-position model, plus hand-computed pins
module tb_alu_8_bit_bist;
    localparam int ND = 4;

    function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    function automatic logic [15:0] mstep(logic [15:0] m, logic [7:0] d);
        int x = int'(m) * 2;
        if (x >= 'h10000) x = (x - 'h10000) ^ 'h1021;
        return 16'(x ^ int'(d));
    endfunction

    function automatic logic [15:0] lstep(logic [15:0] l);
        int x = int'(l);
        int fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
        return 16'((x * 2 + fb) % 65536);
    endfunction

    function automatic logic [15:0] model_sig(int n, logic [15:0] seed);
        logic [15:0] l = seed;
        logic [15:0] m = 16'h0000;
        for (int v = 0; v < n; v++) begin
            for (int o = 0; o < 8; o++) m = mstep(m, alu_f(l[15:8], l[7:0], 3'(o)));
            l = lstep(l);
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD = model_sig(64, 16'hACE1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, flt = 1'b0;
    logic [7:0] rnd = 8'h00;
    logic [7:0] a_v [ND], b_v [ND], alu_v [ND];
    logic [2:0] op_v [ND];
    logic busy_v [ND], done_v [ND], pass_v [ND];
    logic [15:0] sig_v [ND];
    int pass_cnt = 0, tot = 0;
    int t [ND];
    logic [15:0] ms [ND], ml [ND];

    always #5 clk = ~clk;

    alu_8_bit_bist #(.NUM_VECTORS(1), .LFSR_SEED(16'hACE1), .GOLDEN_SIG(16'h0000)) u_z (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a_v[0]), .b_o(b_v[0]), .op_o(op_v[0]),
        .alu_i(alu_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .pass_o(pass_v[0]), .signature_o(sig_v[0]));
    alu_8_bit_bist #(.NUM_VECTORS(64), .LFSR_SEED(16'hACE1), .GOLDEN_SIG(GOLD)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a_v[1]), .b_o(b_v[1]), .op_o(op_v[1]),
        .alu_i(alu_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .pass_o(pass_v[1]), .signature_o(sig_v[1]));
    alu_8_bit_bist #(.NUM_VECTORS(64), .LFSR_SEED(16'hACE1), .GOLDEN_SIG(GOLD ^ 16'h0001)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a_v[2]), .b_o(b_v[2]), .op_o(op_v[2]),
        .alu_i(alu_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .pass_o(pass_v[2]), .signature_o(sig_v[2]));
    alu_8_bit_bist #(.NUM_VECTORS(5), .LFSR_SEED(16'h0000), .GOLDEN_SIG(16'h0000)) u_r (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a_v[3]), .b_o(b_v[3]), .op_o(op_v[3]),
        .alu_i(alu_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]), .pass_o(pass_v[3]), .signature_o(sig_v[3]));

    assign alu_v[0] = 8'h00;
    assign alu_v[1] = alu_f(a_v[1], b_v[1], op_v[1]) | {7'b0, flt};
    assign alu_v[2] = alu_f(a_v[2], b_v[2], op_v[2]);
    assign alu_v[3] = rnd;

    function automatic int nv(int i);
        return i == 0 ? 1 : i == 3 ? 5 : 64;
    endfunction
    function automatic logic [15:0] sd(int i);
        return i == 3 ? 16'h0001 : 16'hACE1;
    endfunction
    function automatic logic [15:0] gd(int i);
        return i == 1 ? GOLD : i == 2 ? GOLD ^ 16'h0001 : 16'h0000;
    endfunction
    // result the ALU hands to controller i this cycle, from the model's own operands
    function automatic logic [7:0] dat(int i);
        logic [2:0] op = 3'((t[i] - 1) % 8);
        logic [7:0] r = alu_f(ml[i][15:8], ml[i][7:0], op);
        return i == 0 ? 8'h00 : i == 3 ? rnd : i == 1 ? r | {7'b0, flt} : r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        tot++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // t = cycles since the accepted start edge (0 = idle after reset)
    initial begin : model
        int n;
        logic run, fin;
        forever begin
            @(posedge clk);
            for (int i = 0; i < ND; i++) begin
                n = nv(i);
                if (rst) begin
                    t[i] = 0;
                    ms[i] = 16'h0000;
                end else if ((t[i] == 0 || t[i] >= 8 * n + 2) && start) begin
                    t[i] = 1;
                    ms[i] = 16'h0000;
                    ml[i] = sd(i);
                end else if (t[i] > 0) begin
                    if (t[i] <= 8 * n) begin
                        ms[i] = mstep(ms[i], dat(i));
                        if (t[i] % 8 == 0) ml[i] = lstep(ml[i]);
                    end
                    if (t[i] < 8 * n + 2) t[i]++;
                end
            end
            #1;
            for (int i = 0; i < ND; i++) begin
                n = nv(i);
                run = t[i] >= 1 && t[i] <= 8 * n;
                fin = t[i] >= 8 * n + 2;
                chk($sformatf("a_o[%0d]", i), int'(a_v[i]), run ? int'(ml[i][15:8]) : 0);
                chk($sformatf("b_o[%0d]", i), int'(b_v[i]), run ? int'(ml[i][7:0]) : 0);
                chk($sformatf("op_o[%0d]", i), int'(op_v[i]), run ? (t[i] - 1) % 8 : 0);
                chk($sformatf("busy_o[%0d]", i), int'(busy_v[i]), int'(t[i] >= 1 && t[i] <= 8 * n + 1));
                chk($sformatf("done_o[%0d]", i), int'(done_v[i]), int'(fin));
                chk($sformatf("pass_o[%0d]", i), int'(pass_v[i]), int'(fin && ms[i] == gd(i)));
                chk($sformatf("signature_o[%0d]", i), int'(sig_v[i]), int'(ms[i]));
            end
        end
    end

    initial forever begin
        @(negedge clk);
        rnd = 8'($urandom);
    end

    task automatic run(logic ign, logic fault, output int lat);
        logic inj = 1'b0;
        int f = int'($urandom_range(3, 480));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done_v[1] && lat < 700) begin
            start = ign && lat > 2 && lat < 505 && $urandom_range(0, 15) == 0;
            flt = fault && !inj && lat >= f && alu_v[1][0] == 1'b0;
            inj = inj || flt;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        flt = 1'b0;
        chk("done reached", int'(done_v[1]), 1);
        chk("start-to-done latency", lat, 514);
        if (fault) chk("fault injected", int'(inj), 1);
    endtask

    initial begin
        int lat;
        logic seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle busy", int'(busy_v[1]), 0);
        chk("idle done", int'(done_v[1]), 0);
        chk("idle a/b/op", int'({a_v[1], b_v[1], op_v[1]}), 0);
        chk("idle signature", int'(sig_v[1]), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk("stub a_o", int'(a_v[0]), 'hAC);
        chk("stub b_o", int'(b_v[0]), 'hE1);
        chk("zero-seed operands", int'({a_v[3], b_v[3]}), 'h0001);
        while (lat < 10) begin
            if (lat <= 8) chk("stub op sweep", int'(op_v[0]), lat - 1);
            if (lat == 2) chk("first absorb", int'(sig_v[1]), 'h008D);
            if (lat == 3) chk("second absorb", int'(sig_v[1]), 'h01D1);
            if (lat == 9) begin
                chk("second vector", int'({a_v[1], b_v[1]}), 'h59C3);
                chk("stub done early", int'(done_v[0]), 0);
            end
            @(negedge clk);
            lat++;
        end
        chk("stub done at 10", int'(done_v[0]), 1);
        chk("stub pass", int'(pass_v[0]), 1);
        chk("stub signature", int'(sig_v[0]), 0);
        while (!done_v[1] && lat < 700) begin
            @(negedge clk);
            lat++;
        end
        chk("full run latency", lat, 514);
        chk("full signature", int'(sig_v[1]), int'(GOLD));
        chk("golden pass", int'(pass_v[1]), 1);
        chk("off-by-one-bit golden", int'(pass_v[2]), 0);
        chk("mismatch signature", int'(sig_v[2]), int'(GOLD));
        run(1'b1, 1'b0, lat);
        chk("restart signature", int'(sig_v[1]), int'(GOLD));
        chk("restart pass", int'(pass_v[1]), 1);
        run(1'b0, 1'b1, lat);
        chk("fault signature differs", int'(sig_v[1] != GOLD), 1);
        chk("fault pass", int'(pass_v[1]), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort outputs", int'({busy_v[1], done_v[1], pass_v[1], op_v[1], a_v[1], b_v[1]}), 0);
        chk("abort signature", int'(sig_v[1]), 0);
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            seen = seen | done_v[1];
        end
        chk("no done after abort", int'(seen), 0);
        run(1'b0, 1'b0, lat);
        chk("post-abort signature", int'(sig_v[1]), int'(GOLD));
        chk("post-abort pass", int'(pass_v[1]), 1);
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, tot);
        $fatal(1);
    end
endmodule
